// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - opcodes, issue FSM states and instruction field layout
package alu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    kADDL = 4'h0, kSUB = 4'h1, kXOR = 4'h2, kNOT = 4'h3, kSRA = 4'h4,
    kSLO  = 4'h5, kSRG = 4'h6, kSLG = 4'h7, kBL  = 4'h8, kBMH = 4'h9
  } op_mne;

  typedef enum logic [1:0] {IDLE, DEC, EXEC, WB} issue_state_t;

  localparam int INSTR_W = 10;
  localparam int OPC_HI  = 9;
  localparam int OPC_LO  = 6;
  localparam int RA_HI   = 5;
  localparam int RA_LO   = 3;
  localparam int RB_HI   = 2;
  localparam int RB_LO   = 0;
  localparam logic [2:0] BR_TGT_REG = 3'd7;

  function automatic logic op_sets_carry(input logic [3:0] op);
    return (op == kADDL) || (op == kSRG) || (op == kSLG);
  endfunction

  function automatic logic op_is_branch(input logic [3:0] op);
    return (op == kBL) || (op == kBMH);
  endfunction

  function automatic logic op_writes_reg(input logic [3:0] op);
    return op_sets_carry(op) || (op == kSUB) || (op == kXOR) || (op == kNOT) ||
           (op == kSRA) || (op == kSLO);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction handshake plus ALU operand/result bus
interface alu_issue_ctrl_if;
  logic [9:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_scin;
  logic [7:0] alu_out;
  logic       alu_scout;
  logic       alu_brflag;

  modport master (
    output instr, instr_valid, alu_out, alu_scout, alu_brflag,
    input  instr_ready, alu_op, alu_a, alu_b, alu_scin
  );

  modport slave (
    input  instr, instr_valid, alu_out, alu_scout, alu_brflag,
    output instr_ready, alu_op, alu_a, alu_b, alu_scin
  );
endinterface

// File: rtl/alu_issue_ctrl_reg_file.sv
// rtl/alu_issue_ctrl_reg_file.sv - 8x8 register file, two read ports, debug read, one write
module alu_issue_ctrl_reg_file (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [2:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [2:0] i_raddr_a,
  output logic [7:0] o_rdata_a,
  input  logic [2:0] i_raddr_b,
  output logic [7:0] o_rdata_b,
  input  logic [2:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);
  logic [7:0] r_mem [8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - 4-cycle issue/writeback controller wrapped around an external ALU
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  alu_issue_ctrl_if.slave  io_bus,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_carry,
  output logic             o_done,
  input  logic [2:0]       i_dbg_addr,
  output logic [7:0]       o_dbg_data
);
  issue_state_t      r_state, w_next;
  logic [9:0]        r_instr;
  logic [3:0]        r_alu_op;
  logic [7:0]        r_alu_a, r_alu_b, r_res;
  logic              r_sc, r_br, r_carry;
  logic [PC_W-1:0]   r_pc;
  logic              w_ready, w_done, w_we;
  logic [3:0]        w_opc;
  logic [2:0]        w_ra, w_rb, w_raddr_a;
  logic [7:0]        w_rd_a, w_rd_b;
  logic [PC_W-1:0]   w_tgt;

  assign w_opc = r_instr[OPC_HI:OPC_LO];
  assign w_ra  = r_instr[RA_HI:RA_LO];
  assign w_rb  = r_instr[RB_HI:RB_LO];
  assign w_tgt = PC_W'(w_rd_a);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Port A doubles as the branch-target read in WB, after any earlier writeback landed
  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_done    = 1'b0;
    w_we      = 1'b0;
    w_raddr_a = w_ra;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (io_bus.instr_valid) w_next = DEC;
      end
      DEC:  w_next = EXEC;
      EXEC: w_next = WB;
      WB: begin
        w_done    = 1'b1;
        w_we      = op_writes_reg(w_opc);
        w_raddr_a = BR_TGT_REG;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr  <= '0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_res    <= '0;
      r_sc     <= 1'b0;
      r_br     <= 1'b0;
      r_carry  <= 1'b0;
      r_pc     <= '0;
    end else begin
      case (r_state)
        IDLE: if (io_bus.instr_valid) r_instr <= io_bus.instr;
        DEC: begin
          r_alu_a  <= w_rd_a;
          r_alu_b  <= w_rd_b;
          r_alu_op <= w_opc;
        end
        EXEC: begin
          r_res <= io_bus.alu_out;
          r_sc  <= io_bus.alu_scout;
          r_br  <= io_bus.alu_brflag;
        end
        WB: begin
          if (op_sets_carry(w_opc)) r_carry <= r_sc;
          if (op_is_branch(w_opc) && r_br) r_pc <= w_tgt;
          else                             r_pc <= r_pc + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

  alu_issue_ctrl_reg_file u_rf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_we       (w_we),
    .i_waddr    (w_ra),
    .i_wdata    (r_res),
    .i_raddr_a  (w_raddr_a),
    .o_rdata_a  (w_rd_a),
    .i_raddr_b  (w_rb),
    .o_rdata_b  (w_rd_b),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  assign io_bus.instr_ready = w_ready;
  assign io_bus.alu_op      = r_alu_op;
  assign io_bus.alu_a       = r_alu_a;
  assign io_bus.alu_b       = r_alu_b;
  assign io_bus.alu_scin    = r_carry;
  assign o_pc               = r_pc;
  assign o_carry            = r_carry;
  assign o_done             = w_done;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed and random checks of alu_issue_ctrl against an ALU stand-in
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pc;
  logic       carry, done;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.PC_W(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .io_bus     (bus),
    .o_pc       (pc),
    .o_carry    (carry),
    .o_done     (done),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ALU stand-in: {br, sc, out}; undefined outputs come from noise, override forces all three
  logic [9:0] noise = '0;
  logic [9:0] ovr = '0;
  logic       ovr_en = 1'b0;
  logic [9:0] alu_resp;

  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin,
                                        input logic [9:0] nz);
    logic [8:0] s;
    logic [7:0] o;
    logic       sc, br;
    o  = nz[7:0];
    sc = nz[8];
    br = nz[9];
    case (op)
      kADDL: begin s = {1'b0, a} + {1'b0, b} + {8'h00, cin}; o = s[7:0]; sc = s[8]; end
      kSUB:  o = a - b;
      kXOR:  o = a ^ b;
      kNOT:  o = ~a;
      kSRA:  o = {a[7], a[7:1]};
      kSLO:  o = {a[6:0], 1'b0};
      kSRG:  begin o = {cin, a[7:1]}; sc = a[0]; end
      kSLG:  begin o = {a[6:0], cin}; sc = a[7]; end
      kBL:   br = (a < b);
      kBMH:  br = (a[7:4] == b[7:4]);
      default: ;
    endcase
    return {br, sc, o};
  endfunction

  always_comb alu_resp = ovr_en ? ovr : alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_scin, noise);
  assign bus.alu_out    = alu_resp[7:0];
  assign bus.alu_scout  = alu_resp[8];
  assign bus.alu_brflag = alu_resp[9];

  // Architectural reference state
  logic [7:0] m_reg [8];
  logic [7:0] m_pc;
  logic       m_carry;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_pc = 8'h00;
    m_carry = 1'b0;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb);
    logic [9:0] r;
    r = ovr_en ? ovr : alu_fn(op, m_reg[ra], m_reg[rb], m_carry, noise);
    if (op inside {kADDL, kSRG, kSLG}) begin
      m_reg[ra] = r[7:0];
      m_carry = r[8];
    end else if (op inside {kSUB, kXOR, kNOT, kSRA, kSLO}) begin
      m_reg[ra] = r[7:0];
    end
    if ((op inside {kBL, kBMH}) && r[9]) m_pc = m_reg[7];
    else                                 m_pc = m_pc + 8'd1;
  endtask

  task automatic check_state();
    check("pc", pc, m_pc);
    check("carry", carry, m_carry);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check($sformatf("r%0d", i), dbg_data, m_reg[i]);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                     input logic use_ovr, input logic [9:0] ov);
    logic [7:0] ea, eb;
    logic       ecin;
    int         done_at;
    @(negedge clk);
    check("ready_idle", bus.instr_ready, 1'b1);
    noise = 10'($urandom);
    ovr_en = use_ovr;
    ovr = ov;
    ea = m_reg[ra];
    eb = m_reg[rb];
    ecin = m_carry;
    model_exec(op, ra, rb);
    bus.instr = {op, ra, rb};
    bus.instr_valid = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr = 10'($urandom);
      if (c == 2) begin
        check("alu_op", bus.alu_op, op);
        check("alu_a", bus.alu_a, ea);
        check("alu_b", bus.alu_b, eb);
        check("alu_scin", bus.alu_scin, ecin);
      end
      if (done) begin
        done_at = c;
        break;
      end
    end
    check("done_latency", done_at, 3);
    @(negedge clk);
    check("done_pulse_end", done, 1'b0);
    check_state();
    ovr_en = 1'b0;
  endtask

  task automatic load(input logic [2:0] ra, input logic [7:0] val);
    run(kXOR, ra, ra, 1'b1, {2'b00, val});
  endtask

  task automatic set_carry(input logic c);
    run(kADDL, 3'd0, 3'd0, 1'b1, {1'b0, c, m_reg[0]});
  endtask

  task automatic set_pc(input logic [7:0] p);
    load(3'd7, p);
    run(kBL, 3'd0, 3'd0, 1'b1, 10'h200);
  endtask

  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    dbg_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_alu_op", bus.alu_op, 4'h0);
    check("rst_alu_a", bus.alu_a, 8'h00);
    check("rst_alu_b", bus.alu_b, 8'h00);
    check_state();
    rst_n = 1'b1;

    // ADDL carry out, then carry in
    load(3'd1, 8'hF0);
    load(3'd2, 8'h20);
    set_carry(1'b0);
    run(kADDL, 3'd1, 3'd2, 1'b0, '0);
    dbg_addr = 3'd1; #1;
    check("addl_r1", dbg_data, 8'h10);
    check("addl_carry", carry, 1'b1);
    run(kADDL, 3'd1, 3'd2, 1'b0, '0);
    dbg_addr = 3'd1; #1;
    check("addl_cin_r1", dbg_data, 8'h31);

    // Non-carry op keeps the flag
    set_carry(1'b1);
    load(3'd3, 8'h5A);
    run(kXOR, 3'd3, 3'd3, 1'b0, '0);
    dbg_addr = 3'd3; #1;
    check("xor_r3", dbg_data, 8'h00);
    check("xor_carry", carry, 1'b1);

    // BMH taken then not taken
    load(3'd4, 8'hA3);
    load(3'd5, 8'hA7);
    set_pc(8'h04);
    load(3'd7, 8'h40);
    run(kBMH, 3'd4, 3'd5, 1'b0, '0);
    check("bmh_taken_pc", pc, 8'h40);
    load(3'd5, 8'h57);
    set_pc(8'h04);
    load(3'd7, 8'h40);
    run(kBMH, 3'd4, 3'd5, 1'b0, '0);
    check("bmh_not_taken_pc", pc, 8'h06);

    // VALID held high: one accept every 4 cycles
    @(negedge clk);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      check("hs_ready", bus.instr_ready, (k % 4) == 0);
      check("hs_done", done, (k % 4) == 3);
      if (k < 10) begin
        bus.instr_valid = 1'b1;
        bus.instr = {4'($urandom_range(0, 9)), 6'($urandom)};
        if (k % 4 == 0) begin
          noise = 10'($urandom);
          model_exec(bus.instr[9:6], bus.instr[5:3], bus.instr[2:0]);
        end
      end else begin
        bus.instr_valid = 1'b0;
      end
    end
    check_state();

    // PC wrap
    set_pc(8'hFF);
    run(kSUB, 3'd0, 3'd0, 1'b0, '0);
    check("wrap_pc", pc, 8'h00);
    dbg_addr = 3'd0; #1;
    check("wrap_r0", dbg_data, 8'h00);

    // Reset during EXEC aborts the instruction
    load(3'd3, 8'hC3);
    set_carry(1'b1);
    @(negedge clk);
    noise = 10'($urandom);
    bus.instr = {kADDL, 3'd3, 3'd3};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_alu_a", bus.alu_a, 8'h00);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", bus.instr_ready, 1'b1);
    check_state();

    // Random instruction stream
    for (int i = 0; i < 8; i++) load(3'(i), 8'($urandom));
    set_carry(1'($urandom));
    for (int i = 0; i < 120; i++)
      run(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
